filter_event_decim: RTL and testbench

Digital back end for one filter_p_m channel. It synchronises the comparator output `high_buf` and samples it on a strobe from the phi clock generator. Each sample is returned as the registered 1-bit feedback `fb1`. The block counts comparator "high" events over a programmable window of samples and buffers each window count in a small FIFO. The readout block drains that FIFO over a valid/ready handshake.

---
 rtl/filter_event_decim.sv | 240 ++++++++++++++++++++++++
 tb/tb_filter_event_decim.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_event_decim.sv
// filter_event_decim: digital back end for one filter_p_m channel.
// Synchronises the comparator output, samples it on each phi strobe, returns
// the sampled bit as registered feedback, counts "high" samples over a
// programmable window and queues each window count in a small FIFO that the
// readout drains over a valid/ready handshake.
module filter_event_decim #(
   parameter int CNT_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sample_stb,
   input  logic             high_buf,
   input  logic [CNT_W-1:0] win_len,
   output logic             fb1,
   output logic [CNT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Registers and next-state signals
   // ---------------------------------------------------------------------
   logic [1:0]       sync_q;
   logic             hb_s;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
   logic [CNT_W-1:0] ones_cnt_q, ones_cnt_d;
   logic             fb1_q, fb1_d;

   logic             push_s;
   logic [CNT_W-1:0] push_data_s;
   logic [CNT_W:0]   samp_plus1_s;

   logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [CNT_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overflow_q, overflow_d;

   logic             pop_s;
   logic             full_s;
   logic             accept_s;
   logic             drop_s;

   // Only the second synchroniser stage is ever used by the logic.
   assign hb_s = sync_q[1];

   // Two-flop synchroniser for the asynchronous comparator output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], high_buf};
      end
   end

   // Window length compare needs one extra bit so samp_cnt+1 cannot wrap.
   assign samp_plus1_s = {1'b0, samp_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

   // Channel FSM, sample counters, feedback bit and window-close push request.
   always_comb begin
      state_d     = state_q;
      samp_cnt_d  = samp_cnt_q;
      ones_cnt_d  = ones_cnt_q;
      fb1_d       = fb1_q;
      push_s      = 1'b0;
      push_data_s = {CNT_W{1'b0}};

      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_ARM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (sample_stb) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A strobe counts only when already running and still enabled; the
      // ARM strobe merely primes fb1 because the synchroniser may be stale.
      if (!en || (state_q != ST_RUN)) begin
         samp_cnt_d = {CNT_W{1'b0}};
         ones_cnt_d = {CNT_W{1'b0}};
      end else if (sample_stb) begin
         if (win_len == {CNT_W{1'b0}}) begin
            samp_cnt_d = {CNT_W{1'b0}};
            ones_cnt_d = {CNT_W{1'b0}};
         end else if (samp_plus1_s >= {1'b0, win_len}) begin
            // >= rather than == so a shrunk win_len closes on the next sample.
            push_s      = 1'b1;
            push_data_s = ones_cnt_q + CNT_W'(hb_s);
            samp_cnt_d  = {CNT_W{1'b0}};
            ones_cnt_d  = {CNT_W{1'b0}};
         end else begin
            samp_cnt_d = samp_plus1_s[CNT_W-1:0];
            ones_cnt_d = ones_cnt_q + CNT_W'(hb_s);
         end
      end else begin
         samp_cnt_d = samp_cnt_q;
         ones_cnt_d = ones_cnt_q;
      end

      // fb1 follows every acted-on strobe in ARM or RUN and holds otherwise.
      if (en && sample_stb && (state_q != ST_IDLE)) begin
         fb1_d = hb_s;
      end else begin
         fb1_d = fb1_q;
      end
   end

   // FSM state, counters and feedback register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         samp_cnt_q <= {CNT_W{1'b0}};
         ones_cnt_q <= {CNT_W{1'b0}};
         fb1_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         samp_cnt_q <= samp_cnt_d;
         ones_cnt_q <= ones_cnt_d;
         fb1_q      <= fb1_d;
      end
   end

   // Result FIFO next state; the head is precomputed so out_data is a flop.
   always_comb begin
      pop_s    = out_valid_q && out_ready;
      full_s   = (occ_q == OCC_W'(FIFO_DEPTH));
      accept_s = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;

      if (accept_s) begin
         mem_d[wr_ptr_q] = push_data_s;
         wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({accept_s, pop_s})
         2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
         2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
         default: occ_d = occ_q;
      endcase

      out_valid_d = (occ_d != {OCC_W{1'b0}});
      if (out_valid_d) begin
         out_data_d = mem_d[rd_ptr_d];
      end else begin
         out_data_d = {CNT_W{1'b0}};
      end

      // A new drop outranks a clear issued in the same cycle.
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO storage, pointers, occupancy and registered readout outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {CNT_W{1'b0}};
         end
         rd_ptr_q    <= {PTR_W{1'b0}};
         wr_ptr_q    <= {PTR_W{1'b0}};
         occ_q       <= {OCC_W{1'b0}};
         out_data_q  <= {CNT_W{1'b0}};
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         occ_q       <= occ_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign fb1       = fb1_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_filter_event_decim.sv
// Testbench for filter_event_decim: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a window-level reference model.
module tb_filter_event_decim;

   localparam int CNT_W = 8;
   localparam int DEPTH = 4;
   localparam int SB_SZ = 4096;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sample_stb;
   logic             high_buf;
   logic [CNT_W-1:0] win_len;
   logic             fb1;
   logic [CNT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             overflow;
   logic             clr_ovf;

   always #5 clk = ~clk;

   filter_event_decim #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sample_stb (sample_stb),
      .high_buf   (high_buf),
      .win_len    (win_len),
      .fb1        (fb1),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   // ------------------------------------------------------------------
   // Reference model (written only by the model process)
   // ------------------------------------------------------------------
   int occ_m;          // expected FIFO occupancy
   bit fb_m;
   bit ovf_m;
   bit active_m;       // enabled long enough to act on strobes
   bit running_m;      // first strobe seen, samples now counted
   bit h1_m, h2_m;     // high_buf seen one and two edges ago
   int win_bits_m[$];  // samples of the open window
   int exp_mem[SB_SZ]; // scoreboard of accepted window counts
   int wr_idx = 0;

   // Scoreboard read side (written only by the monitor)
   int rd_idx = 0;
   int n_chk  = 0;
   int n_fail = 0;

   // Window-level model: a strobe sees high_buf from two edges earlier.
   always @(posedge clk or posedge rst) begin : model_blk
      bit hb;
      bit pop;
      bit push;
      bit drop;
      int val;
      int wl;
      if (rst) begin
         occ_m     = 0;
         fb_m      = 1'b0;
         ovf_m     = 1'b0;
         active_m  = 1'b0;
         running_m = 1'b0;
         h1_m      = 1'b0;
         h2_m      = 1'b0;
         win_bits_m.delete();
      end else begin
         hb   = h2_m;
         h2_m = h1_m;
         h1_m = high_buf;
         pop  = (occ_m > 0) && out_ready;
         push = 1'b0;
         drop = 1'b0;
         val  = 0;
         wl   = int'(win_len);
         if (!en) begin
            active_m  = 1'b0;
            running_m = 1'b0;
            win_bits_m.delete();
         end else if (!active_m) begin
            active_m = 1'b1;
         end else if (sample_stb) begin
            fb_m = hb;
            if (!running_m) begin
               running_m = 1'b1;
            end else if (wl == 0) begin
               win_bits_m.delete();
            end else if (win_bits_m.size() + 1 >= wl) begin
               val = int'(hb);
               foreach (win_bits_m[k]) val += win_bits_m[k];
               push = 1'b1;
               win_bits_m.delete();
            end else begin
               win_bits_m.push_back(int'(hb));
            end
         end
         if (push && (occ_m >= DEPTH) && !pop) begin
            drop = 1'b1;
         end
         if (pop) occ_m--;
         if (push && !drop) begin
            exp_mem[wr_idx % SB_SZ] = val;
            wr_idx++;
            occ_m++;
         end
         if (drop) ovf_m = 1'b1;
         else if (clr_ovf) ovf_m = 1'b0;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on handshakes.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_fb1", int'(fb1), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out_data", int'(out_data), 0);
         chk("rst_overflow", int'(overflow), 0);
         rd_idx = wr_idx;
      end else begin
         chk("out_valid", int'(out_valid), (occ_m > 0) ? 1 : 0);
         chk("overflow", int'(overflow), int'(ovf_m));
         chk("fb1", int'(fb1), int'(fb_m));
         if (out_valid) begin
            if (rd_idx == wr_idx) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_underflow: out_valid=1 with out_data=%0d but no result expected at %0t",
                        out_data, $time);
            end else begin
               chk("out_data", int'(out_data), exp_mem[rd_idx % SB_SZ]);
               if (out_ready) rd_idx++;
            end
         end else begin
            chk("out_data_empty", int'(out_data), 0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after each rising edge
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One strobe whose sampled value is b (high_buf settles through the sync).
   task automatic stb_bit(input bit b);
      high_buf = b;
      tick();
      tick();
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
   endtask

   // n back-to-back strobes with a constant comparator level.
   task automatic stb_burst(input int n, input bit b);
      high_buf = b;
      tick();
      tick();
      sample_stb = 1'b1;
      repeat (n) tick();
      sample_stb = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      sample_stb = 1'b0;
      high_buf   = 1'b0;
      win_len    = 8'd0;
      out_ready  = 1'b0;
      clr_ovf    = 1'b0;

      // Reset held while every input toggles.
      for (int i = 0; i < 6; i++) begin
         en         = 1'($urandom_range(1, 0));
         sample_stb = 1'($urandom_range(1, 0));
         high_buf   = 1'($urandom_range(1, 0));
         out_ready  = 1'($urandom_range(1, 0));
         clr_ovf    = 1'($urandom_range(1, 0));
         win_len    = 8'($urandom_range(255, 0));
         tick();
      end
      en = 1'b0; sample_stb = 1'b0; high_buf = 1'b0;
      out_ready = 1'b0; clr_ovf = 1'b0;
      rst = 1'b0;
      tick();

      // Basic window: 1,0,1,1,0 after the ARM strobe gives 3.
      win_len = 8'd5;
      en = 1'b1;
      tick();
      stb_bit(1'b0);
      stb_bit(1'b1); stb_bit(1'b0); stb_bit(1'b1); stb_bit(1'b1); stb_bit(1'b0);
      tick();
      drain();

      // Five windows of 2 into a 4-deep FIFO with no reader.
      win_len = 8'd2;
      stb_burst(10, 1'b1);
      tick(); tick();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      drain();

      // Full FIFO, then a window closes while the reader pops.
      stb_bit(1'b0); stb_bit(1'b1);
      stb_bit(1'b1); stb_bit(1'b1);
      stb_bit(1'b1); stb_bit(1'b0);
      stb_bit(1'b0); stb_bit(1'b0);
      high_buf = 1'b1;
      tick(); tick();
      sample_stb = 1'b1;
      tick();
      out_ready = 1'b1;
      tick();
      sample_stb = 1'b0;
      out_ready = 1'b0;
      tick(); tick();
      drain();

      // win_len shrinks 8 -> 3 with 5 samples counted.
      win_len = 8'd8;
      for (int i = 0; i < 5; i++) stb_bit(1'($urandom_range(1, 0)));
      win_len = 8'd3;
      stb_bit(1'b1);
      tick();
      drain();

      // en drops mid-window, then re-arms from scratch.
      win_len = 8'd6;
      for (int i = 0; i < 3; i++) stb_bit(1'b1);
      en = 1'b0;
      tick(); tick();
      en = 1'b1;
      tick();
      stb_bit(1'b1);
      for (int i = 0; i < 6; i++) stb_bit(1'($urandom_range(1, 0)));
      drain();

      // win_len = 0: no pushes, fb1 keeps tracking.
      win_len = 8'd0;
      for (int i = 0; i < 20; i++) stb_bit(1'($urandom_range(1, 0)));
      tick();

      // Maximum window, all ones.
      win_len = 8'd255;
      stb_burst(255, 1'b1);
      tick();
      drain();

      // Asynchronous reset mid-window with two results queued.
      win_len = 8'd2;
      stb_burst(4, 1'b1);
      win_len = 8'd5;
      stb_burst(2, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         en         = ($urandom_range(19, 0) != 0);
         sample_stb = ($urandom_range(2, 0) == 0);
         high_buf   = 1'($urandom_range(1, 0));
         out_ready  = ($urandom_range(3, 0) == 0);
         clr_ovf    = ($urandom_range(15, 0) == 0);
         rst        = ($urandom_range(599, 0) == 0);
         if ($urandom_range(63, 0) == 0) begin
            case ($urandom_range(4, 0))
               0:       win_len = 8'd0;
               1:       win_len = 8'd1;
               2:       win_len = 8'd2;
               3:       win_len = 8'd3;
               default: win_len = 8'($urandom_range(12, 4));
            endcase
         end
         tick();
      end
      rst = 1'b0;
      en = 1'b0;
      sample_stb = 1'b0;
      clr_ovf = 1'b0;
      drain();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
